// File: rtl/muldiv_unit_pkg.sv
// Shared execute-stage types for the integer multiply/divide engine:
// word and decoded-op types, engine FSM states, and op-class helpers.
package muldiv_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MFHI,
        OP_MFLO
    } decoded_op_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } muldiv_state_t;

    localparam int MUL_LAT_DEFAULT   = 3;
    localparam int DIV_ITERS_DEFAULT = 32;

    function automatic logic is_muldiv_op(input decoded_op_t op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_mul_op(input decoded_op_t op);
        return op inside {OP_MULT, OP_MULTU};
    endfunction

    function automatic logic is_signed_op(input decoded_op_t op);
        return op inside {OP_MULT, OP_DIV};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage functional unit <-> mul/div engine connection.
// master = functional unit side, slave = engine side.
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic        flushE;
    logic        first_cycleE;
    logic        multen;
    decoded_op_t mult_op;
    word_t       multsrca;
    word_t       multsrcb;
    word_t       hi;
    word_t       lo;
    logic        multok;

    modport master (
        output flushE, first_cycleE, multen, mult_op, multsrca, multsrcb,
        input  hi, lo, multok
    );

    modport slave (
        input  flushE, first_cycleE, multen, mult_op, multsrca, multsrcb,
        output hi, lo, multok
    );

endinterface

// File: rtl/muldiv_unit_div_step.sv
// One restoring radix-2 division iteration on unsigned magnitudes.
// The trial remainder is 33 bits so divisors with bit 31 set still work.
module muldiv_unit_div_step
    import muldiv_unit_pkg::*;
(
    input  word_t rem,
    input  word_t q,
    input  word_t divisor,
    output word_t rem_nxt,
    output word_t q_nxt
);

    logic [32:0] trial;
    logic [32:0] diff;
    logic        fits;

    assign trial   = {rem, q[31]};
    assign diff    = trial - {1'b0, divisor};
    assign fits    = ~diff[32];
    assign rem_nxt = fits ? diff[31:0] : trial[31:0];
    assign q_nxt   = {q[30:0], fits};

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine returning HI/LO with a registered
// completion flag; one operation at a time, restartable and flushable.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MUL_LAT   = MUL_LAT_DEFAULT,
    parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    muldiv_unit_if.slave  bus
);

    localparam int CNT_MAX = (DIV_ITERS > MUL_LAT) ? DIV_ITERS : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    muldiv_state_t     state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              start;
    logic              load, step, wr_mul, wr_div;

    word_t             hi_q, lo_q;
    logic              ok_q;

    word_t             srca_p0, srcb_p0;
    logic              sgn_p0;
    word_t             rem_p1, q_p1, dvsr_p1;
    word_t             rem_step, q_step;

    logic signed [32:0] mul_a_p0, mul_b_p0;
    logic signed [63:0] prod_p0;
    logic signed [63:0] prod_tap;
    logic [63:0]        div_res;

    function automatic word_t magnitude(input word_t v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

    // Divide-by-zero bypasses the sign fix so the result is deterministic.
    function automatic logic [63:0] fix_result(input word_t q, input word_t rem,
                                               input word_t a, input word_t b,
                                               input logic sgn);
        word_t qf, rf;
        if (b == '0) begin
            return {a, 32'hFFFF_FFFF};
        end
        qf = (sgn && (a[31] ^ b[31])) ? -q : q;
        rf = (sgn && a[31]) ? -rem : rem;
        return {rf, qf};
    endfunction

    assign start = bus.multen & bus.first_cycleE & ~bus.flushE & is_muldiv_op(bus.mult_op);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        step      = 1'b0;
        wr_mul    = 1'b0;
        wr_div    = 1'b0;
        if (bus.flushE) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (start) begin
            load      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = is_mul_op(bus.mult_op) ? MUL : DIV;
        end else begin
            unique case (state)
                MUL: begin
                    if (cnt == CNT_W'(MUL_LAT - 2)) begin
                        wr_mul    = 1'b1;
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                DIV: begin
                    step = 1'b1;
                    if (cnt == CNT_W'(DIV_ITERS - 1)) begin
                        state_nxt = FIX;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    wr_div    = 1'b1;
                    state_nxt = DONE;
                end
                IDLE, DONE: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage p0: operand capture; stage p1: division iteration registers.
    always_ff @(posedge clk) begin
        if (load) begin
            srca_p0 <= bus.multsrca;
            srcb_p0 <= bus.multsrcb;
            sgn_p0  <= is_signed_op(bus.mult_op);
            rem_p1  <= '0;
            q_p1    <= magnitude(bus.multsrca, is_signed_op(bus.mult_op));
            dvsr_p1 <= magnitude(bus.multsrcb, is_signed_op(bus.mult_op));
        end else if (step) begin
            rem_p1  <= rem_step;
            q_p1    <= q_step;
        end
    end

    muldiv_unit_div_step u_div_step (
        .rem     (rem_p1),
        .q       (q_p1),
        .divisor (dvsr_p1),
        .rem_nxt (rem_step),
        .q_nxt   (q_step)
    );

    assign mul_a_p0 = {sgn_p0 & srca_p0[31], srca_p0};
    assign mul_b_p0 = {sgn_p0 & srcb_p0[31], srcb_p0};
    assign prod_p0  = 64'(mul_a_p0) * 64'(mul_b_p0);

    // Retiming stages behind the multiplier; the tap is valid once the
    // counter has walked MUL_LAT-1 cycles from the operand capture.
    if (MUL_LAT == 2) begin : g_mul_comb
        assign prod_tap = prod_p0;
    end else begin : g_mul_pipe
        logic signed [63:0] prod_pipe [MUL_LAT-2];
        always_ff @(posedge clk) begin
            prod_pipe[0] <= prod_p0;
            for (int i = 1; i < MUL_LAT - 2; i++) begin
                prod_pipe[i] <= prod_pipe[i-1];
            end
        end
        assign prod_tap = prod_pipe[MUL_LAT-3];
    end

    assign div_res = fix_result(q_p1, rem_p1, srca_p0, srcb_p0, sgn_p0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            ok_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ok_q  <= (state_nxt == DONE);
            if (wr_mul) begin
                {hi_q, lo_q} <= prod_tap;
            end else if (wr_div) begin
                {hi_q, lo_q} <= div_res;
            end
        end
    end

    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
    assign bus.multok = ok_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model compared
// every cycle, plus literal result and latency expectations per vector.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int MUL_LAT   = 3;
    localparam int DIV_ITERS = 32;
    localparam int MUL_CYC   = MUL_LAT;
    localparam int DIV_CYC   = DIV_ITERS + 2;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    muldiv_unit_if mif ();

    muldiv_unit #(.MUL_LAT(MUL_LAT), .DIV_ITERS(DIV_ITERS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model_res(input decoded_op_t op, input word_t a, input word_t b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            OP_DIV, OP_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (op == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return 64'h0;
        endcase
    endfunction

    logic        m_ok;
    word_t       m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_cd;

    // Model: a start schedules its result latency-1 edges later; flush cancels.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ok   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_cd   <= 0;
            m_pend <= '0;
        end else if (mif.flushE) begin
            m_ok <= 1'b0;
            m_cd <= 0;
        end else if (mif.multen && mif.first_cycleE &&
                     (mif.mult_op == OP_MULT || mif.mult_op == OP_MULTU ||
                      mif.mult_op == OP_DIV  || mif.mult_op == OP_DIVU)) begin
            m_ok   <= 1'b0;
            m_pend <= model_res(mif.mult_op, mif.multsrca, mif.multsrcb);
            m_cd   <= ((mif.mult_op == OP_MULT || mif.mult_op == OP_MULTU) ? MUL_CYC : DIV_CYC) - 1;
        end else if (m_cd == 1) begin
            m_ok         <= 1'b1;
            {m_hi, m_lo} <= m_pend;
            m_cd         <= 0;
        end else if (m_cd > 1) begin
            m_cd <= m_cd - 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("multok_model", 64'(mif.multok), 64'(m_ok));
            check("hi_model", 64'(mif.hi), 64'(m_hi));
            check("lo_model", 64'(mif.lo), 64'(m_lo));
        end
    end

    // Issue one op in cycle 0 (called just after a rising edge) and wait for multok.
    task automatic run_op(input decoded_op_t op, input word_t a, input word_t b,
                          input int lat, input word_t ehi, input word_t elo, input string name);
        int seen_at;
        seen_at          = -1;
        mif.multen       = 1'b1;
        mif.first_cycleE = 1'b1;
        mif.mult_op      = op;
        mif.multsrca     = a;
        mif.multsrcb     = b;
        for (int c = 0; c <= lat + 4; c++) begin
            @(negedge clk);
            if (c == 1) check({name, "_okfall"}, 64'(mif.multok), 64'h0);
            if (c >= 1 && mif.multok && seen_at < 0) seen_at = c;
            @(posedge clk);
            #1;
            mif.first_cycleE = 1'b0;
            if (seen_at >= 0) break;
        end
        check({name, "_latency"}, 64'(seen_at), 64'(lat));
        check({name, "_hi"}, 64'(mif.hi), 64'(ehi));
        check({name, "_lo"}, 64'(mif.lo), 64'(elo));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int ok_seen;
        checks   = 0;
        failures = 0;
        reset            = 1'b1;
        mif.flushE       = 1'b0;
        mif.first_cycleE = 1'b0;
        mif.multen       = 1'b0;
        mif.mult_op      = OP_NOP;
        mif.multsrca     = '0;
        mif.multsrcb     = '0;
        tick(3);
        check("reset_hi", 64'(mif.hi), 64'h0);
        check("reset_lo", 64'(mif.lo), 64'h0);
        check("reset_ok", 64'(mif.multok), 64'h0);
        reset = 1'b0;
        tick(2);

        run_op(OP_MULT,  32'hFFFF_FFFE, 32'h3,          MUL_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  MUL_CYC, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000,  MUL_CYC, 32'h4000_0000, 32'h0000_0000, "mult_minmin");
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h2,          DIV_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
        run_op(OP_DIVU,  32'd100,       32'd7,          DIV_CYC, 32'd2,         32'd14,        "divu_100_7");
        run_op(OP_DIVU,  32'h1234,      32'h0,          DIV_CYC, 32'h1234,      32'hFFFF_FFFF, "divu_by0");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  DIV_CYC, 32'h0,         32'h8000_0000, "div_wrap");
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE,  DIV_CYC, 32'd1,         32'hFFFF_FFFD, "div_7_neg2");
        run_op(OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0001,  DIV_CYC, 32'h7FFF_FFFE, 32'd1,         "divu_bigdiv");

        // Flush a DIV in cycle 10, then start MULT 5x5 in cycle 12.
        mif.multen       = 1'b1;
        mif.first_cycleE = 1'b1;
        mif.mult_op      = OP_DIV;
        mif.multsrca     = 32'd1000;
        mif.multsrcb     = 32'd3;
        tick(1);
        mif.first_cycleE = 1'b0;
        tick(9);
        mif.flushE = 1'b1;
        tick(1);
        mif.flushE = 1'b0;
        tick(1);
        check("flush_ok", 64'(mif.multok), 64'h0);
        check("flush_hi_hold", 64'(mif.hi), 64'h7FFF_FFFE);
        check("flush_lo_hold", 64'(mif.lo), 64'h1);
        run_op(OP_MULT, 32'd5, 32'd5, MUL_CYC, 32'd0, 32'd25, "mult_after_flush");

        // Hold in DONE for four cycles, then back-to-back DIVU.
        tick(4);
        check("done_hold_ok", 64'(mif.multok), 64'h1);
        check("done_hold_lo", 64'(mif.lo), 64'd25);
        run_op(OP_DIVU, 32'd9, 32'd4, DIV_CYC, 32'd1, 32'd2, "b2b_divu");

        // Flush together with a start: nothing may begin.
        mif.first_cycleE = 1'b1;
        mif.flushE       = 1'b1;
        mif.mult_op      = OP_MULT;
        mif.multsrca     = 32'd6;
        mif.multsrcb     = 32'd7;
        tick(1);
        mif.first_cycleE = 1'b0;
        mif.flushE       = 1'b0;
        tick(6);
        check("flushstart_ok", 64'(mif.multok), 64'h0);
        check("flushstart_lo", 64'(mif.lo), 64'd2);
        check("flushstart_hi", 64'(mif.hi), 64'd1);

        // A non-mul/div op code never starts the engine.
        mif.first_cycleE = 1'b1;
        mif.mult_op      = OP_ADD;
        tick(1);
        mif.first_cycleE = 1'b0;
        tick(6);
        check("badop_ok", 64'(mif.multok), 64'h0);

        // Reset pulsed in cycle 20 of a DIV.
        mif.first_cycleE = 1'b1;
        mif.mult_op      = OP_DIV;
        mif.multsrca     = 32'd50;
        mif.multsrcb     = 32'd5;
        tick(1);
        mif.first_cycleE = 1'b0;
        tick(19);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_hi", 64'(mif.hi), 64'h0);
        check("midreset_lo", 64'(mif.lo), 64'h0);
        check("midreset_ok", 64'(mif.multok), 64'h0);
        tick(2);
        reset   = 1'b0;
        ok_seen = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (mif.multok) ok_seen++;
        end
        check("no_spurious_ok", 64'(ok_seen), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
